// File: rtl/stdcore_pkg.sv
// stdcore_pkg: helpers shared by the stdcore FIFO family.
package stdcore_pkg;

    // Ceiling log2, usable in parameter defaults.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Wrap base+offset into [0, depth) with a single compare-subtract.
    // Callers guarantee base < depth and offset <= depth.
    function automatic int unsigned mod_add(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned depth);
        int unsigned s;
        s = base + off;
        return (s >= depth) ? s - depth : s;
    endfunction

endpackage

// File: rtl/stdcore_2prf.sv
// stdcore_2prf: two-port register file, one write port and one read port.
// Enables are active-low; the read port returns zero while disabled.
module stdcore_2prf
    import stdcore_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 6,
    parameter int unsigned DEPTH = 64
) (
    input  logic          clk,
    input  logic          we_n,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re_n,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (!we_n) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = re_n ? '0 : mem_q[raddr];

endmodule

// File: rtl/stdcore_cbfifo.sv
// stdcore_cbfifo: block FIFO with random access inside the open push block and
// the head pull block, for arbitrary DEPTH. Zero-masking of never-written
// entries is built in when STDCORE_CBFIFO_ZMASK_EN is defined.
module stdcore_cbfifo
    import stdcore_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          flush,
    input  logic [DW-1:0] p,
    input  logic [AW-1:0] p_waddr,
    input  logic          p_we,
    input  logic [AW:0]   p_blk,
    input  logic          p_commit,
    output logic          p_rdy,
    output logic [AW:0]   p_vc,
    output logic          p_werr,
    output logic [DW-1:0] c,
    input  logic [AW-1:0] c_raddr,
    input  logic          c_re,
    input  logic [AW:0]   c_blk,
    input  logic          c_release,
    output logic          c_rdy,
    output logic [AW:0]   c_st,
    output logic          c_rerr
);

    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] p_base_q, p_base_d;
    logic [AW-1:0] c_base_q, c_base_d;
    logic [AW:0]   c_st_q, c_st_d;
    logic [DW-1:0] c_q, c_d;
    logic          p_werr_q, p_werr_d;
    logic          c_rerr_q, c_rerr_d;

    logic          wr_ok, rd_ok, fire_p, fire_c;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          ram_we_n, ram_re_n;
    logic [DW-1:0] ram_rdata;
    logic          rd_valid;

    // Handshake status is combinational from registered counts and block sizes only.
    assign p_vc   = DEPTH_C - c_st_q;
    assign p_rdy  = (p_blk <= p_vc);
    assign c_rdy  = (c_blk <= c_st_q);
    assign c_st   = c_st_q;
    assign c      = c_q;
    assign p_werr = p_werr_q;
    assign c_rerr = c_rerr_q;

    assign ram_we_n = ~wr_ok;
    assign ram_re_n = ~rd_ok;

    stdcore_2prf #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we_n  (ram_we_n),
        .waddr (wr_addr),
        .wdata (p),
        .re_n  (ram_re_n),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

`ifdef STDCORE_CBFIFO_ZMASK_EN
    logic [DEPTH-1:0] valid_q, valid_d;
    int unsigned      rel;

    assign rd_valid = valid_q[rd_addr];

    // Valid bitmap update: set on accepted write, then cleared over the
    // released range so a same-cycle release of the entry wins.
    always_comb begin
        valid_d = valid_q;
        rel     = 0;
        if (wr_ok) begin
            valid_d[wr_addr] = 1'b1;
        end
        if (fire_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rel = (i >= 32'(c_base_q)) ? i - 32'(c_base_q) : i + DEPTH - 32'(c_base_q);
                if (rel < 32'(c_blk)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        if (flush) begin
            valid_d = '0;
        end
    end

    // Valid bitmap register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end
`else
    assign rd_valid = 1'b1;
`endif

    // Accept terms, physical addresses and next base/count/output values.
    always_comb begin
        wr_ok   = p_we && ({1'b0, p_waddr} < p_vc) && !flush;
        rd_ok   = c_re && ({1'b0, c_raddr} < c_st_q) && !flush;
        fire_p  = p_commit && p_rdy;
        fire_c  = c_release && c_rdy;
        wr_addr = AW'(mod_add(32'(p_base_q), 32'(p_waddr), DEPTH));
        rd_addr = AW'(mod_add(32'(c_base_q), 32'(c_raddr), DEPTH));

        p_base_d = p_base_q;
        c_base_d = c_base_q;
        if (fire_p) begin
            p_base_d = AW'(mod_add(32'(p_base_q), 32'(p_blk), DEPTH));
        end
        if (fire_c) begin
            c_base_d = AW'(mod_add(32'(c_base_q), 32'(c_blk), DEPTH));
        end
        c_st_d   = c_st_q + (fire_p ? p_blk : '0) - (fire_c ? c_blk : '0);
        p_werr_d = p_we && !wr_ok;
        c_rerr_d = c_re && !rd_ok;
        c_d      = c_q;
        if (c_re) begin
            c_d = (rd_ok && rd_valid) ? ram_rdata : '0;
        end

        if (flush) begin
            p_base_d = '0;
            c_base_d = '0;
            c_st_d   = '0;
            p_werr_d = 1'b0;
            c_rerr_d = 1'b0;
            c_d      = '0;
        end
    end

    // Base, count and output registers.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            p_base_q <= '0;
            c_base_q <= '0;
            c_st_q   <= '0;
            c_q      <= '0;
            p_werr_q <= 1'b0;
            c_rerr_q <= 1'b0;
        end else begin
            p_base_q <= p_base_d;
            c_base_q <= c_base_d;
            c_st_q   <= c_st_d;
            c_q      <= c_d;
            p_werr_q <= p_werr_d;
            c_rerr_q <= c_rerr_d;
        end
    end

endmodule

// File: tb/tb_stdcore_cbfifo.sv
// tb_stdcore_cbfifo: scoreboard bench for stdcore_cbfifo at DEPTH=6.
module tb_stdcore_cbfifo;

    localparam int DW    = 8;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] p = '0;
    logic [AW-1:0] p_waddr = '0;
    logic          p_we = 1'b0;
    logic [AW:0]   p_blk = '0;
    logic          p_commit = 1'b0;
    logic          p_rdy;
    logic [AW:0]   p_vc;
    logic          p_werr;
    logic [DW-1:0] c;
    logic [AW-1:0] c_raddr = '0;
    logic          c_re = 1'b0;
    logic [AW:0]   c_blk = '0;
    logic          c_release = 1'b0;
    logic          c_rdy;
    logic [AW:0]   c_st;
    logic          c_rerr;

    always #5 clk = ~clk;

    stdcore_cbfifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .flush     (flush),
        .p         (p),
        .p_waddr   (p_waddr),
        .p_we      (p_we),
        .p_blk     (p_blk),
        .p_commit  (p_commit),
        .p_rdy     (p_rdy),
        .p_vc      (p_vc),
        .p_werr    (p_werr),
        .c         (c),
        .c_raddr   (c_raddr),
        .c_re      (c_re),
        .c_blk     (c_blk),
        .c_release (c_release),
        .c_rdy     (c_rdy),
        .c_st      (c_st),
        .c_rerr    (c_rerr)
    );

    typedef struct {
        bit chk_c;
        int c;
        bit rerr;
        bit werr;
        bit prdy;
        bit crdy;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: physical contents, which entries hold bench-written
    // data, per-entry valid flags, the two bases and the stock.
    int m_mem[DEPTH];
    bit m_known[DEPTH];
    bit m_vld[DEPTH];
    int m_pb, m_cb, m_st, m_c;
    bit m_c_known;

    function automatic void chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pb = 0;
        m_cb = 0;
        m_st = 0;
        m_c = 0;
        m_c_known = 1'b1;
        for (int k = 0; k < DEPTH; k++) m_vld[k] = 1'b0;
    endfunction

    // One clock of stimulus: drive inputs at the falling edge, advance the
    // model, queue what the DUT must show after the next rising edge.
    task automatic step(input int we, input int wa, input int d, input int cm, input int pb,
                        input int re, input int ra, input int rl, input int cb, input int fl);
        int   vc, pa, rp;
        bit   wok, rok, fp, fc;
        exp_t e;
        @(negedge clk);
        p_we = 1'(we); p_waddr = 3'(wa); p = 8'(d); p_commit = 1'(cm); p_blk = 4'(pb);
        c_re = 1'(re); c_raddr = 3'(ra); c_release = 1'(rl); c_blk = 4'(cb); flush = 1'(fl);
        vc  = DEPTH - m_st;
        wok = (we != 0) && (wa < vc);
        rok = (re != 0) && (ra < m_st);
        fp  = (cm != 0) && (pb <= vc);
        fc  = (rl != 0) && (cb <= m_st);
        pa  = (m_pb + wa) % DEPTH;
        rp  = (m_cb + ra) % DEPTH;
        e.werr = 1'b0;
        e.rerr = 1'b0;
        if (fl != 0) begin
            model_reset();
        end else begin
            if (re != 0) begin
                if (!rok) begin
                    m_c = 0; m_c_known = 1'b1;
                end else begin
`ifdef STDCORE_CBFIFO_ZMASK_EN
                    if (!m_vld[rp]) begin
                        m_c = 0; m_c_known = 1'b1;
                    end else begin
                        m_c = m_mem[rp]; m_c_known = m_known[rp];
                    end
`else
                    m_c = m_mem[rp]; m_c_known = m_known[rp];
`endif
                end
            end
            e.werr = (we != 0) && !wok;
            e.rerr = (re != 0) && !rok;
            if (wok) begin
                m_mem[pa] = d & 8'hff; m_known[pa] = 1'b1; m_vld[pa] = 1'b1;
            end
            if (fc) for (int k = 0; k < cb; k++) m_vld[(m_cb + k) % DEPTH] = 1'b0;
            if (fp) m_pb = (m_pb + pb) % DEPTH;
            if (fc) m_cb = (m_cb + cb) % DEPTH;
            m_st = m_st + (fp ? pb : 0) - (fc ? cb : 0);
        end
        e.st    = m_st;
        e.prdy  = (pb <= DEPTH - m_st);
        e.crdy  = (cb <= m_st);
        e.c     = m_c;
        e.chk_c = m_c_known;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every registered output is presented after a rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_c) chk("c", int'(c), e.c);
                chk("c_rerr", int'(c_rerr), int'(e.rerr));
                chk("p_werr", int'(p_werr), int'(e.werr));
                chk("c_st", int'(c_st), e.st);
                chk("p_vc", int'(p_vc), DEPTH - e.st);
                chk("p_rdy", int'(p_rdy), int'(e.prdy));
                chk("c_rdy", int'(c_rdy), int'(e.crdy));
            end
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k] = 0; m_known[k] = 1'b0;
        end
        model_reset();

        // Reset state, including p_rdy/c_rdy boundaries on block size.
        #1;
        chk("rst_c_st", int'(c_st), 0);
        chk("rst_p_vc", int'(p_vc), DEPTH);
        chk("rst_c", int'(c), 0);
        chk("rst_p_werr", int'(p_werr), 0);
        chk("rst_c_rerr", int'(c_rerr), 0);
        chk("rst_p_rdy_0", int'(p_rdy), 1);
        chk("rst_c_rdy_0", int'(c_rdy), 1);
        p_blk = 4'(DEPTH); c_blk = 4'd1; #1;
        chk("rst_p_rdy_depth", int'(p_rdy), 1);
        chk("rst_c_rdy_1", int'(c_rdy), 0);
        p_blk = 4'(DEPTH + 1); #1;
        chk("rst_p_rdy_over", int'(p_rdy), 0);
        p_blk = '0; c_blk = '0;
        @(negedge clk); arst = 1'b0;

        // Args: we, wa, d, commit, p_blk, re, ra, release, c_blk, flush.
        // Write 0..2, commit 3, read 2 and 0.
        step(1, 0, 8'hA0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8'hA1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 8'hA2, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle();
        // Move both bases to 4, then commit 4 across the wrap and release 3.
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        step(1, 0, 8'h5A, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 8'hB0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8'hB1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 8'hB2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3, 8'hB3, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, k, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Fill to full; commit 1 refused and write dropped.
        for (int k = 0; k < 5; k++) step(1, k, 8'hC0 + k, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        step(1, 0, 8'hEE, 1, 1, 1, 5, 0, 0, 0);
        // Release 2, then commit 2 with release 2 in the same cycle.
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        step(1, 0, 8'hD0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0, 0, 1, 2, 0);
        // Out-of-range read at stock 2, out-of-range write at vacancy 4.
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 5, 8'h77, 0, 0, 1, 1, 0, 0, 0);
        // Empty, write offsets 0 and 2, commit 4, read the unwritten offset 1.
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        step(1, 0, 8'h10, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 8'h12, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        // Flush in the middle of a block.
        step(1, 1, 8'h99, 1, 2, 1, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            step(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 99) == 0));
        end

        // Asynchronous reset in the middle of an open block.
        step(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        step(1, 0, 8'h31, 1, 3, 0, 0, 0, 0, 0);
        step(1, 1, 8'h32, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        p_we = 1'b0; p_commit = 1'b0; c_re = 1'b0; c_release = 1'b0; flush = 1'b0;
        p_blk = '0; c_blk = '0;
        #1 arst = 1'b1;
        #1;
        chk("arst_c_st", int'(c_st), 0);
        chk("arst_p_vc", int'(p_vc), DEPTH);
        chk("arst_c", int'(c), 0);
        chk("arst_p_werr", int'(p_werr), 0);
        chk("arst_c_rerr", int'(c_rerr), 0);
        chk("arst_p_rdy", int'(p_rdy), 1);
        chk("arst_c_rdy", int'(c_rdy), 1);
        #1 arst = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle();
        idle();

        @(posedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
